// File: rtl/camera_pkg.sv
// Shared definitions for the camera pixel reader.
// Holds the Avalon register offsets, the STATUS/CTRL bit positions, the
// fetch FSM state encoding and a helper that assembles the STATUS word.
package camera_pkg;

  // Avalon register offsets
  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_VALID   = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_TIMEOUT = 3;

  // CTRL bit positions
  localparam int CTRL_AUTOINC = 0;
  localparam int CTRL_CLEAR   = 1;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_REQ        = 2'd2;
  localparam logic [1:0] ST_WAIT_DATA  = 2'd3;

  // Build the 32-bit STATUS readback word; unused bits read as zero.
  function automatic logic [31:0] status_word(input logic valid,
                                              input logic busy,
                                              input logic overrun,
                                              input logic timeout);
    logic [31:0] w;
    w               = 32'd0;
    w[STAT_VALID]   = valid;
    w[STAT_BUSY]    = busy;
    w[STAT_OVERRUN] = overrun;
    w[STAT_TIMEOUT] = timeout;
    return w;
  endfunction

endpackage

// File: rtl/camera_pixel_reader_if.sv
// Bus bundle for the camera pixel reader.
// Carries the Avalon-MM slave signals (address, chipselect, write_n, read_n,
// writedata, readdata) and the frame-buffer read port (frame_busy,
// mem_rd_req, mem_rd_addr, mem_rd_valid, mem_rd_data).
//   slave  : the pixel reader side
//   master : the CPU / frame-buffer side (testbench)
interface camera_pixel_reader_if #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 8
);

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              frame_busy;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [PIX_W-1:0]  mem_rd_data;

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata,
    input  frame_busy,
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_valid, mem_rd_data
  );

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata,
    output frame_busy,
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_valid, mem_rd_data
  );

endinterface

// File: rtl/camera_fetch_fsm.sv
// Fetch sequencer for the camera pixel reader.
// Waits for the camera writer to release the buffer, issues a single-cycle
// read request and waits a bounded time for the returned pixel.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   start_i, start_addr_i  begin a fetch at the given pixel address (IDLE only)
//   frame_busy_i         camera writer owns the buffer
//   mem_rd_valid_i       read data returned by the frame buffer
//   busy_o               a fetch is in progress
//   capture_o            pulse: pixel data is on mem_rd_data this cycle
//   timeout_o            pulse: the fetch gave up waiting
//   mem_rd_req_o, mem_rd_addr_o  frame-buffer read request
module camera_fetch_fsm
  import camera_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              frame_busy_i,
  input  logic              mem_rd_valid_i,
  output logic              busy_o,
  output logic              capture_o,
  output logic              timeout_o,
  output logic              mem_rd_req_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o
);

  // Counter holds the number of WAIT_DATA cycles already spent; the last
  // allowed value is TIMEOUT-1, so the give-up edge lands TIMEOUT cycles
  // after the request cycle.
  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              capture_s;
  logic              timeout_s;

  // Next-state, request and timeout-counter logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = 1'b0;
    fetch_addr_d = fetch_addr_q;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          fetch_addr_d = start_addr_i;
          if (frame_busy_i) begin
            state_d = ST_WAIT_FRAME;
          end else begin
            // Request flop rises together with the REQ state
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_busy_i) begin
          state_d = ST_WAIT_FRAME;
        end else begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (mem_rd_valid_i) begin
          capture_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered request port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      req_q        <= 1'b0;
      fetch_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign capture_o     = capture_s;
  assign timeout_o     = timeout_s;
  assign mem_rd_req_o  = req_q;
  assign mem_rd_addr_o = fetch_addr_q;

endmodule

// File: rtl/camera_pixel_reader.sv
// Avalon-MM slave that reads single pixels out of the camera frame buffer.
// Register map: ADDR (RW, write starts a fetch), DATA (RO, last pixel;
// with autoinc a read of a valid pixel advances ADDR and fetches the next),
// STATUS (RO: valid, busy, overrun, timeout) and CTRL (autoinc, W1C clear).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   bus           Avalon slave + frame-buffer read port (slave modport)
module camera_pixel_reader
  import camera_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  camera_pixel_reader_if.slave  bus
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              autoinc_q, autoinc_d;

  logic              wr_s;
  logic              rd_s;
  logic              addr_wr_s;
  logic              ctrl_wr_s;
  logic              inc_rd_s;
  logic              start_s;
  logic              overrun_evt_s;
  logic [ADDR_W-1:0] start_addr_s;
  logic              busy_s;
  logic              capture_s;
  logic              timeout_evt_s;
  logic [31:0]       readdata_s;
  logic              unused_wdata_s;

  // Only the low bits of writedata are meaningful for any register
  assign unused_wdata_s = ^bus.writedata;

  camera_fetch_fsm #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_s),
    .start_addr_i   (start_addr_s),
    .frame_busy_i   (bus.frame_busy),
    .mem_rd_valid_i (bus.mem_rd_valid),
    .busy_o         (busy_s),
    .capture_o      (capture_s),
    .timeout_o      (timeout_evt_s),
    .mem_rd_req_o   (bus.mem_rd_req),
    .mem_rd_addr_o  (bus.mem_rd_addr)
  );

  // Bus decode: fetch start, overrun detection and the address a new fetch uses
  always_comb begin
    wr_s      = bus.chipselect & ~bus.write_n;
    rd_s      = bus.chipselect & ~bus.read_n;
    addr_wr_s = wr_s & (bus.address == REG_ADDR);
    ctrl_wr_s = wr_s & (bus.address == REG_CTRL);
    // Auto-increment only fires on a DATA read that actually returns a fresh pixel
    inc_rd_s  = rd_s & (bus.address == REG_DATA) & autoinc_q & valid_q;
    start_s       = (addr_wr_s | inc_rd_s) & ~busy_s;
    overrun_evt_s = (addr_wr_s | inc_rd_s) & busy_s;
    if (addr_wr_s) begin
      start_addr_s = bus.writedata[ADDR_W-1:0];
    end else begin
      start_addr_s = addr_q + ADDR_W'(1);
    end
  end

  // Register-file next-state logic
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    autoinc_d = autoinc_q;

    if (start_s) begin
      addr_d = start_addr_s;
    end else begin
      addr_d = addr_q;
    end

    if (capture_s) begin
      data_d = bus.mem_rd_data;
    end else begin
      data_d = data_q;
    end

    // start only happens in IDLE and capture only in WAIT_DATA, so they never collide
    if (start_s) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end

    // A new event wins over a simultaneous clear so it is never lost
    if (overrun_evt_s) begin
      overrun_d = 1'b1;
    end else if (ctrl_wr_s & bus.writedata[CTRL_CLEAR]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (timeout_evt_s) begin
      timeout_d = 1'b1;
    end else if (ctrl_wr_s & bus.writedata[CTRL_CLEAR]) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    if (ctrl_wr_s) begin
      autoinc_d = bus.writedata[CTRL_AUTOINC];
    end else begin
      autoinc_d = autoinc_q;
    end
  end

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= {PIX_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      autoinc_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      autoinc_q <= autoinc_d;
    end
  end

  // Zero-wait-state read mux; drives zero when no read is in progress
  always_comb begin
    readdata_s = 32'd0;
    if (rd_s) begin
      case (bus.address)
        REG_ADDR:   readdata_s = 32'(addr_q);
        REG_DATA:   readdata_s = 32'(data_q);
        REG_STATUS: readdata_s = status_word(valid_q, busy_s, overrun_q, timeout_q);
        REG_CTRL:   readdata_s = {31'd0, autoinc_q};
        default:    readdata_s = 32'd0;
      endcase
    end else begin
      readdata_s = 32'd0;
    end
  end

  assign bus.readdata = readdata_s;

endmodule

// File: doc/camera_pixel_reader.md
# camera_pixel_reader

Avalon-MM slave that pulls single pixels out of the camera frame buffer for the Nios II MNIST software. It is the read side of the frame-buffer path: the CPU writes a 12-bit pixel address, the block fetches the pixel through a request/valid memory port and exposes it in a readable register. An auto-increment mode streams consecutive pixels, such as a 28x28 = 784-pixel MNIST window, one DATA read at a time.

## Interface
Parameters:
- ADDR_W, 12, pixel address width; frame buffer depth is 2^ADDR_W.
- PIX_W, 8, pixel data width.
- TIMEOUT, 255, maximum cycles to wait for mem_rd_valid; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- read_n  in  1  Avalon read strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states, unused bits 0.
- frame_busy  in  1  camera writer owns the buffer; no fetch may be issued while high.
- mem_rd_req  out  1  single-cycle read request pulse.
- mem_rd_addr  out  ADDR_W  request address; valid while mem_rd_req is high.
- mem_rd_valid  in  1  read data valid; arbitrary latency ≥1 cycle after the request.
- mem_rd_data  in  PIX_W  read data.

## Operation
Registers:
- 0 ADDR, RW, [ADDR_W-1:0]. A write loads ADDR and starts a fetch.
- 1 DATA, RO, [PIX_W-1:0]. Holds the last fetched pixel. When CTRL.autoinc=1 and STATUS.valid=1, a read increments ADDR (4095 wraps to 0) and starts a fetch.
- 2 STATUS, RO. bit0 valid, bit1 busy, bit2 overrun (sticky), bit3 timeout (sticky).
- 3 CTRL, RW. bit0 autoinc. bit1 is write-1-to-clear for overrun and timeout; it reads as 0.

FSM states are IDLE, WAIT_FRAME, REQ and WAIT_DATA. busy = (state != IDLE).
- IDLE, on a fetch start: clear valid. Go to WAIT_FRAME if frame_busy=1, otherwise to REQ.
- WAIT_FRAME: stay while frame_busy=1; go to REQ when it is 0. No timeout applies in this state.
- REQ: assert mem_rd_req for exactly one cycle with mem_rd_addr=ADDR. Load the timeout counter with 0. Go to WAIT_DATA.
- WAIT_DATA: on mem_rd_valid, capture mem_rd_data into DATA, set valid and go to IDLE. Otherwise increment the counter; when it reaches TIMEOUT, set timeout, leave valid=0 and DATA unchanged, and go to IDLE.
- Any ADDR write or auto-increment DATA read while busy=1 is ignored and sets overrun. The in-flight fetch is unaffected.
- A DATA read while valid=0 returns the stale DATA and has no side effect.
- A mem_rd_valid outside WAIT_DATA is ignored.
- A CTRL write to autoinc takes effect for the next DATA read.

Reset values: ADDR=0, DATA=0, STATUS=0, CTRL=0, state=IDLE, mem_rd_req=0, mem_rd_addr=0, readdata=0. Asserting reset mid-fetch aborts the fetch immediately. A mem_rd_valid arriving after reset is released is ignored.

## Timing
- Writes take effect at the clock edge where chipselect & ~write_n.
- The side-effect read fires once per read cycle, on chipselect & ~read_n & address==1.
- Fetch start at edge E0 gives busy=1 and valid=0 in the cycle after E0. With frame_busy=0, mem_rd_req is high in the cycle after E0.
- mem_rd_valid sampled at edge En gives DATA updated, valid=1 and busy=0 in the cycle after En. The minimum round trip is 3 cycles from the ADDR write to valid.
- In auto-increment mode, the DATA read at edge E returns the old pixel. ADDR+1 is visible and the fetch starts in the cycle after E.
- A timeout fires exactly TIMEOUT cycles after the REQ cycle when no valid arrives.

## Structure
- The shared package camera_pkg holds the register offsets (REG_ADDR=0, REG_DATA=1, REG_STATUS=2, REG_CTRL=3), the STATUS/CTRL bit indices and the FSM state encoding.
- The sub-module camera_fetch_fsm contains the FSM, the timeout counter and the mem_rd_* port. The top level holds the register file, the read mux and the start/overrun decode.

## Test plan
- Reset, then read all four registers: expect 0. mem_rd_req stays 0.
- Write ADDR=0x123 with frame_busy=0 and a memory model of latency 2 returning 0xA5: expect mem_rd_req with mem_rd_addr=0x123 for one cycle, then DATA=0xA5 and STATUS=0x1.
- Set CTRL=1 and ADDR=0xFFE, then read DATA three times with polling for valid: expect fetch addresses 0xFFE, 0xFFF, 0x000 and DATA following the model contents.
- Hold frame_busy=1 for 50 cycles after an ADDR write: expect no mem_rd_req and busy=1, then a request 1 cycle after frame_busy falls.
- With the model never returning valid and TIMEOUT=255: expect STATUS=0x8 after 255 cycles. Then write CTRL=0x2: expect STATUS=0.
- Write ADDR=0x010 and then ADDR=0x020 while busy: expect overrun set, a single request at 0x010, and ADDR readback 0x010.
